// File: rtl/dut_out_dma_packer.sv
// Output snapshot packer for the XDMA C2H stream.
// Each accepted snapshot lands in one of two ping-pong slots together with a
// 32-bit header {MAGIC, drops-before-this-snapshot, seq}. The oldest slot is
// streamed as NBEATS beats of BEAT_W bits, header in the low bits of beat 0.
// When both slots are full, new snapshots are dropped and counted.
module dut_out_dma_packer #(
    parameter int         DATA_W = 4064,
    parameter int         BEAT_W = 512,
    parameter logic [7:0] MAGIC  = 8'hA5
) (
    input  logic                  xdma_clk,
    input  logic                  xdma_resetn,
    input  logic                  en,
    input  logic                  out_enable,
    input  logic [DATA_W-1:0]     out_io_data,
    output logic [BEAT_W-1:0]     m_axis_tdata,
    output logic [BEAT_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic [31:0]           pkt_sent,
    output logic [31:0]           drop_total
);

    localparam int PKT_W  = DATA_W + 32;
    localparam int NBEATS = PKT_W / BEAT_W;
    localparam int BIDX_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(NBEATS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [BIDX_W-1:0]   beat_q, beat_d;
    logic [1:0]          occ_q, occ_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [15:0]         seq_q, seq_d;
    logic [7:0]          pend_q, pend_d;
    logic [31:0]         pkt_sent_q, pkt_sent_d;
    logic [31:0]         drop_total_q, drop_total_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   slot_data_q [2];
    logic [DATA_W-1:0]   slot_data_d [2];
    logic [31:0]         slot_hdr_q  [2];
    logic [31:0]         slot_hdr_d  [2];

    logic                tvalid_s;
    logic                hs_s;
    logic                last_hs_s;
    logic                cap_s;
    logic                full_s;
    logic                accept_s;
    logic                drop_s;
    logic [PKT_W-1:0]    pkt_s;

    // Handshake and capture qualification; a slot freed by the final beat
    // this edge is already available to an incoming snapshot.
    always_comb begin
        tvalid_s  = (state_q == ST_SEND);
        hs_s      = tvalid_s & m_axis_tready;
        last_hs_s = hs_s & (beat_q == LAST_BEAT);
        cap_s     = en & out_enable;
        full_s    = (occ_q == 2'd2) & ~last_hs_s;
        accept_s  = cap_s & ~full_s;
        drop_s    = cap_s & full_s;
    end

    // Slot bookkeeping: occupancy, pointers, sequence and drop counters.
    always_comb begin
        occ_d        = occ_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        seq_d        = seq_q;
        pend_d       = pend_q;
        pkt_sent_d   = pkt_sent_q;
        drop_total_d = drop_total_q;
        slot_data_d  = slot_data_q;
        slot_hdr_d   = slot_hdr_q;

        case ({accept_s, last_hs_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        if (accept_s) begin
            slot_data_d[wr_ptr_q] = out_io_data;
            slot_hdr_d[wr_ptr_q]  = {MAGIC, pend_q, seq_q};
            wr_ptr_d              = ~wr_ptr_q;
            seq_d                 = seq_q + 16'd1;
            pend_d                = 8'd0;
        end else if (drop_s) begin
            pend_d       = (pend_q == 8'hFF) ? pend_q : pend_q + 8'd1;
            drop_total_d = drop_total_q + 32'd1;
        end else begin
            pend_d = pend_q;
        end

        if (last_hs_s) begin
            rd_ptr_d   = ~rd_ptr_q;
            pkt_sent_d = pkt_sent_q + 32'd1;
        end else begin
            rd_ptr_d   = rd_ptr_q;
        end
    end

    // Send FSM: start a packet when anything is queued, walk the beats on
    // each handshake, and chain straight into the next packet if one waits.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (occ_q != 2'd0) begin
                    state_d = ST_SEND;
                    beat_d  = {BIDX_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (hs_s) begin
                    if (beat_q != LAST_BEAT) begin
                        beat_d = beat_q + {{(BIDX_W-1){1'b0}}, 1'b1};
                    end else begin
                        beat_d  = {BIDX_W{1'b0}};
                        state_d = (occ_d != 2'd0) ? ST_SEND : ST_IDLE;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = {BIDX_W{1'b0}};
            end
        endcase
        busy_d = (occ_d != 2'd0) | (state_d == ST_SEND);
    end

    // Control and counter registers.
    always_ff @(posedge xdma_clk or negedge xdma_resetn) begin
        if (!xdma_resetn) begin
            state_q      <= ST_IDLE;
            beat_q       <= {BIDX_W{1'b0}};
            occ_q        <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            seq_q        <= 16'd0;
            pend_q       <= 8'd0;
            pkt_sent_q   <= 32'd0;
            drop_total_q <= 32'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            occ_q        <= occ_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            seq_q        <= seq_d;
            pend_q       <= pend_d;
            pkt_sent_q   <= pkt_sent_d;
            drop_total_q <= drop_total_d;
            busy_q       <= busy_d;
        end
    end

    // Snapshot slot storage with its headers.
    always_ff @(posedge xdma_clk or negedge xdma_resetn) begin
        if (!xdma_resetn) begin
            slot_data_q[0] <= {DATA_W{1'b0}};
            slot_data_q[1] <= {DATA_W{1'b0}};
            slot_hdr_q[0]  <= 32'd0;
            slot_hdr_q[1]  <= 32'd0;
        end else begin
            slot_data_q <= slot_data_d;
            slot_hdr_q  <= slot_hdr_d;
        end
    end

    // Beat selection from the slot at the read pointer.
    always_comb begin
        pkt_s         = {slot_data_q[rd_ptr_q], slot_hdr_q[rd_ptr_q]};
        m_axis_tdata  = pkt_s[int'(beat_q) * BEAT_W +: BEAT_W];
        m_axis_tkeep  = {(BEAT_W/8){1'b1}};
        m_axis_tvalid = tvalid_s;
        m_axis_tlast  = tvalid_s & (beat_q == LAST_BEAT);
        busy          = busy_q;
        pkt_sent      = pkt_sent_q;
        drop_total    = drop_total_q;
    end

endmodule

// File: doc/dut_out_dma_packer.md
Name: dut_out_dma_packer

Overview:
- Captures each DUT output snapshot (`out_enable` strobe with 4064-bit `out_io_data`) into a 2-entry ping-pong buffer.
- Prepends a 32-bit header and streams the 4096-bit packet as 8 × 512-bit AXI-Stream beats to the XDMA C2H channel.
- Sits between `dut_wrapper` outputs and the DMA stream input, in the `xdma_clk` domain.
- Handles backpressure and counts snapshots lost to overflow.

Parameters:
- DATA_W, 4064, snapshot width.
- BEAT_W, 512, stream beat width.
- MAGIC, 8'hA5, header marker byte.
- Constraint: (DATA_W+32) must be a multiple of BEAT_W. NBEATS = (DATA_W+32)/BEAT_W = 8.

Ports:
- xdma_clk  in  1  sole clock.
- xdma_resetn  in  1  asynchronous active-low reset.
- en  in  1  capture enable; when low, new strobes are ignored (not counted as drops).
- out_enable  in  1  snapshot strobe from DUT, sampled each cycle.
- out_io_data  in  DATA_W  snapshot payload, valid when out_enable=1.
- m_axis_tdata  out  BEAT_W  stream data.
- m_axis_tkeep  out  BEAT_W/8  constant all-ones.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  high on beat NBEATS-1.
- busy  out  1  a slot is occupied or a packet is in flight.
- pkt_sent  out  32  completed packets, wraps.
- drop_total  out  32  dropped snapshots, wraps.

Behaviour:
- **Reset:** asynchronous, active-low. While `xdma_resetn`=0:
  - tvalid, tlast, busy = 0; pkt_sent, drop_total = 0.
  - Both slots empty, seq=0, pending drop counter=0, FSM=IDLE, beat index=0.
  - Assertion mid-packet aborts it immediately: tvalid falls asynchronously and no partial packet resumes after release.
- **Capture:**
  - On a rising edge with en=1 and out_enable=1: if a slot is free, store out_io_data into the write slot, tagged with seq and the pending drop count. Then seq increments (16-bit, wraps 0xFFFF→0) and the pending drop counter clears.
  - If both slots are full: snapshot discarded, pending drop counter increments (8-bit, saturates at 255), drop_total increments.
  - Fullness uses the registered occupancy. Exception: a capture in the same cycle as the final-beat handshake (tvalid & tready & tlast) is accepted even when occupancy=2, because the slot is freed that edge.
  - Slots are written and read in alternating order (1-bit write/read pointers); occupancy is 0..2.
- **Header:**
  - [15:0] seq.
  - [23:16] drops immediately preceding this snapshot.
  - [31:24] MAGIC.
  - Packet P = {snapshot[DATA_W-1:0], header[31:0]}; beat k carries P[512k+511 : 512k].
- **Send FSM:**
  - IDLE: if occupancy>0, go to SEND with beat=0 and tvalid=1 next cycle. Capture at edge N to an empty block gives beat 0 on tvalid at edge N+1 (1-cycle latency).
  - SEND: tvalid=1. On tvalid & tready: if beat<NBEATS-1, beat increments. Else (tlast) free the read slot, toggle the read pointer, increment pkt_sent; then stay in SEND with beat=0 if occupancy after update>0, otherwise return to IDLE.
  - Back-to-back packets therefore have no idle bubble.
  - tdata, tlast and tvalid hold stable while tvalid=1 & tready=0. tvalid never drops before its handshake.
- **busy** = (occupancy≠0) | (state==SEND).
- **Changing en:** does not affect slots already captured or the packet in flight.
- **Counter widths:** all counters wrap except the pending drop counter, which saturates.

Test Plan:
- Single snapshot: reset, en=1, tready=1, one strobe with data=pattern i (byte b = b mod 256).
  - Required: tvalid rises the next cycle.
  - Beat 0 [31:0]=32'hA5000000 and [511:32]=data[479:0].
  - 8 consecutive beats with tlast only on the 8th; pkt_sent=1, busy=0 after.
- Backpressure: tready toggles 1,0,0,1 pseudo-randomly during a packet.
  - Required: tdata and tlast stable while stalled, exactly 8 handshakes, reassembled packet matches.
- Overflow: tready=0, 5 strobes.
  - Required: 2 accepted (seq 0,1), drop_total=3.
  - Then tready=1: seq0 header drops=0, seq1 header drops=0. The next strobe gets seq=2 with drops=3.
- Simultaneous free/capture: occupancy=2 and a strobe coincides with the final-beat handshake.
  - Required: strobe accepted, drop_total unchanged, the next packet starts with no idle cycle.
- Saturation/wrap: 300 drops before an accept gives header drops=255 and drop_total=300. After 65536 accepts, seq wraps to 0.
- Reset mid-packet: assert xdma_resetn=0 at beat 3.
  - Required: tvalid=0 immediately, counters=0.
  - After release with no strobes, tvalid stays 0.
